// File: rtl/writeback_unit.sv
// Writeback stage: merges ALU results and RAM load responses onto the single register-file
// write port, extends loaded bytes/halves, times out lost loads and stalls decode on load-use.
module writeback_unit #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic        Clock,
    input  logic        Reset_n,
    input  logic        Alu_valid,
    input  logic [4:0]  Alu_rd,
    input  logic [31:0] Alu_result,
    input  logic        Load_valid,
    input  logic [4:0]  Load_rd,
    input  logic [2:0]  Load_funct3,
    input  logic [1:0]  Load_byte_off,
    input  logic        Mem_ready,
    input  logic [31:0] Mem_rdata,
    input  logic [4:0]  Rs1_addr,
    input  logic [4:0]  Rs2_addr,
    output logic [4:0]  Write_addr,
    output logic        Write_En,
    output logic [31:0] Write_data,
    output logic        Stall,
    output logic        Load_error
);
    typedef enum logic {IDLE, WAIT_MEM} state_t;

    localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t      state_q;
    logic [4:0]  pend_rd_q;
    logic [2:0]  pend_f3_q;
    logic [1:0]  pend_off_q;
    logic [7:0]  cnt_q;
    logic        skid_full_q;
    logic [4:0]  skid_rd_q;
    logic [31:0] skid_data_q;
    logic        we_q;
    logic [4:0]  wa_q;
    logic [31:0] wd_q;
    logic        err_q;

    logic        waiting;
    logic        resp;
    logic        load_take;
    logic        load_legal;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data_d;

    always_comb begin
        waiting   = (state_q == WAIT_MEM);
        resp      = waiting && Mem_ready;
        // A held load is not taken while the skid entry drains; upstream re-presents it.
        load_take = (state_q == IDLE) && Load_valid && !skid_full_q;

        case (Load_funct3)
            3'd0, 3'd4: load_legal = 1'b1;
            3'd1, 3'd5: load_legal = !Load_byte_off[0];
            3'd2:       load_legal = (Load_byte_off == 2'd0);
            default:    load_legal = 1'b0;
        endcase

        byte_sel = Mem_rdata[{pend_off_q, 3'b000} +: 8];
        half_sel = pend_off_q[1] ? Mem_rdata[31:16] : Mem_rdata[15:0];

        case (pend_f3_q)
            3'd0:    load_data_d = {{24{byte_sel[7]}}, byte_sel};
            3'd1:    load_data_d = {{16{half_sel[15]}}, half_sel};
            3'd4:    load_data_d = {24'd0, byte_sel};
            3'd5:    load_data_d = {16'd0, half_sel};
            default: load_data_d = Mem_rdata;
        endcase
    end

    assign Stall = skid_full_q
                 || (waiting && Load_valid)
                 || (waiting && !Mem_ready && (pend_rd_q != 5'd0)
                     && ((Rs1_addr == pend_rd_q) || (Rs2_addr == pend_rd_q)));

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            state_q     <= IDLE;
            pend_rd_q   <= '0;
            pend_f3_q   <= '0;
            pend_off_q  <= '0;
            cnt_q       <= '0;
            skid_full_q <= 1'b0;
            skid_rd_q   <= '0;
            skid_data_q <= '0;
            we_q        <= 1'b0;
            wa_q        <= '0;
            wd_q        <= '0;
            err_q       <= 1'b0;
        end else begin
            we_q  <= 1'b0;
            err_q <= 1'b0;

            // Skid only ever holds a non-zero rd, so it always writes.
            if (skid_full_q) begin
                skid_full_q <= 1'b0;
                we_q        <= 1'b1;
                wa_q        <= skid_rd_q;
                wd_q        <= skid_data_q;
            end else if (resp) begin
                if (pend_rd_q != 5'd0) begin
                    we_q <= 1'b1;
                    wa_q <= pend_rd_q;
                    wd_q <= load_data_d;
                end
                if (Alu_valid && (Alu_rd != 5'd0)) begin
                    skid_full_q <= 1'b1;
                    skid_rd_q   <= Alu_rd;
                    skid_data_q <= Alu_result;
                end
            end else if (Alu_valid && (Alu_rd != 5'd0)) begin
                we_q <= 1'b1;
                wa_q <= Alu_rd;
                wd_q <= Alu_result;
            end

            case (state_q)
                IDLE: begin
                    if (load_take) begin
                        if (load_legal) begin
                            state_q    <= WAIT_MEM;
                            pend_rd_q  <= Load_rd;
                            pend_f3_q  <= Load_funct3;
                            pend_off_q <= Load_byte_off;
                            cnt_q      <= '0;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                WAIT_MEM: begin
                    if (Mem_ready) begin
                        state_q <= IDLE;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        state_q <= IDLE;
                        err_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign Write_En   = we_q;
    assign Write_addr = wa_q;
    assign Write_data = wd_q;
    assign Load_error = err_q;
endmodule

// File: tb/tb_writeback_unit.sv
// Bench for writeback_unit: directed stimulus, a cycle-level behavioural model compared every
// negedge, and literal expectations taken from the worked examples.
module tb_writeback_unit;
    localparam int MT = 4;

    logic        Clock = 1'b0;
    logic        Reset_n;
    logic        Alu_valid;
    logic [4:0]  Alu_rd;
    logic [31:0] Alu_result;
    logic        Load_valid;
    logic [4:0]  Load_rd;
    logic [2:0]  Load_funct3;
    logic [1:0]  Load_byte_off;
    logic        Mem_ready;
    logic [31:0] Mem_rdata;
    logic [4:0]  Rs1_addr;
    logic [4:0]  Rs2_addr;
    logic [4:0]  Write_addr;
    logic        Write_En;
    logic [31:0] Write_data;
    logic        Stall;
    logic        Load_error;

    int total = 0;
    int bad   = 0;

    writeback_unit #(.MEM_TIMEOUT(MT)) dut (
        .Clock(Clock), .Reset_n(Reset_n),
        .Alu_valid(Alu_valid), .Alu_rd(Alu_rd), .Alu_result(Alu_result),
        .Load_valid(Load_valid), .Load_rd(Load_rd), .Load_funct3(Load_funct3),
        .Load_byte_off(Load_byte_off), .Mem_ready(Mem_ready), .Mem_rdata(Mem_rdata),
        .Rs1_addr(Rs1_addr), .Rs2_addr(Rs2_addr),
        .Write_addr(Write_addr), .Write_En(Write_En), .Write_data(Write_data),
        .Stall(Stall), .Load_error(Load_error)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          known = 1'b0;
    bit          m_busy, m_skid;
    int          m_wait, m_prd, m_f3, m_off, m_srd;
    logic [31:0] m_sval;
    logic [31:0] exp_we, exp_wa, exp_wd, exp_err;

    function automatic int access_size(input int f3);
        if (f3 == 0 || f3 == 4) return 1;
        if (f3 == 1 || f3 == 5) return 2;
        return 4;
    endfunction

    function automatic bit is_legal(input int f3, input int off);
        if (!(f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5)) return 1'b0;
        return (off % access_size(f3)) == 0;
    endfunction

    function automatic logic [31:0] extract(input int f3, input int off, input logic [31:0] w);
        longint v;
        int     bits;
        bits = 8 * access_size(f3);
        v = longint'(w) >> (8 * off);
        v = v & ((longint'(1) << bits) - 1);
        if (f3 < 4 && bits < 32 && v >= (longint'(1) << (bits - 1)))
            v = v - (longint'(1) << bits);
        return v[31:0];
    endfunction

    task automatic m_write(input int rd, input logic [31:0] v);
        if (rd != 0) begin
            exp_we = 32'd1;
            exp_wa = 32'(rd);
            exp_wd = v;
        end
    endtask

    function automatic logic [31:0] m_stall();
        if (m_skid) return 32'd1;
        if (m_busy && Load_valid) return 32'd1;
        if (m_busy && m_prd != 0 && !Mem_ready &&
            (int'(Rs1_addr) == m_prd || int'(Rs2_addr) == m_prd)) return 32'd1;
        return 32'd0;
    endfunction

    always @(posedge Clock) begin : model
        bit was_busy, was_skid;
        if (!Reset_n) begin
            known = 1'b1;
            m_busy = 1'b0; m_skid = 1'b0; m_wait = 0;
            exp_we = '0; exp_wa = '0; exp_wd = '0; exp_err = '0;
        end else if (known) begin
            was_busy = m_busy;
            was_skid = m_skid;
            exp_we  = '0;
            exp_err = '0;
            if (was_skid) begin
                m_write(m_srd, m_sval);
                m_skid = 1'b0;
            end else if (was_busy && Mem_ready) begin
                m_write(m_prd, extract(m_f3, m_off, Mem_rdata));
                if (Alu_valid && Alu_rd != 5'd0) begin
                    m_skid = 1'b1;
                    m_srd  = int'(Alu_rd);
                    m_sval = Alu_result;
                end
            end else if (Alu_valid) begin
                m_write(int'(Alu_rd), Alu_result);
            end
            if (was_busy) begin
                if (Mem_ready) m_busy = 1'b0;
                else begin
                    m_wait++;
                    if (m_wait == MT) begin
                        m_busy  = 1'b0;
                        exp_err = 32'd1;
                    end
                end
            end else if (!was_skid && Load_valid) begin
                if (is_legal(int'(Load_funct3), int'(Load_byte_off))) begin
                    m_busy = 1'b1;
                    m_wait = 0;
                    m_prd  = int'(Load_rd);
                    m_f3   = int'(Load_funct3);
                    m_off  = int'(Load_byte_off);
                end else begin
                    exp_err = 32'd1;
                end
            end
        end
    end

    always @(negedge Clock) begin
        if (known) begin
            chk("write_en",   32'(Write_En),   exp_we);
            chk("write_addr", 32'(Write_addr), exp_wa);
            chk("write_data", Write_data,      exp_wd);
            chk("load_error", 32'(Load_error), exp_err);
            chk("stall",      32'(Stall),      m_stall());
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc();
        @(posedge Clock);
        #1;
    endtask

    task automatic quiet();
        Alu_valid = 1'b0; Load_valid = 1'b0; Mem_ready = 1'b0;
    endtask

    task automatic issue_load(input int f3, input int off, input int rd);
        Load_valid = 1'b1; Load_funct3 = 3'(f3); Load_byte_off = 2'(off); Load_rd = 5'(rd);
    endtask

    task automatic load_and_check(input int f3, input int off, input int rd, input logic [31:0] want);
        issue_load(f3, off, rd);
        cyc();
        Load_valid = 1'b0; Mem_ready = 1'b1; Mem_rdata = 32'h80F1_7F82;
        cyc();
        Mem_ready = 1'b0;
        chk("load_we",   32'(Write_En),   32'd1);
        chk("load_addr", 32'(Write_addr), 32'(rd));
        chk("load_data", Write_data,      want);
    endtask

    initial begin
        Reset_n = 1'b0; quiet();
        Alu_rd = '0; Alu_result = '0; Load_rd = '0; Load_funct3 = '0; Load_byte_off = '0;
        Mem_rdata = '0; Rs1_addr = '0; Rs2_addr = '0;
        cyc(); cyc();
        chk("rst_we",   32'(Write_En),   32'd0);
        chk("rst_addr", 32'(Write_addr), 32'd0);
        chk("rst_data", Write_data,      32'd0);
        chk("rst_err",  32'(Load_error), 32'd0);
        chk("rst_stall", 32'(Stall),     32'd0);
        Reset_n = 1'b1;
        cyc();

        // ALU write and x0 discard
        Alu_valid = 1'b1; Alu_rd = 5'd5; Alu_result = 32'hDEADBEEF;
        cyc();
        Alu_valid = 1'b0;
        chk("alu_we",   32'(Write_En),   32'd1);
        chk("alu_addr", 32'(Write_addr), 32'd5);
        chk("alu_data", Write_data,      32'hDEADBEEF);
        Alu_valid = 1'b1; Alu_rd = 5'd0; Alu_result = 32'h1234_5678;
        cyc();
        Alu_valid = 1'b0;
        chk("x0_we",   32'(Write_En), 32'd0);
        chk("x0_hold", Write_data,    32'hDEADBEEF);
        cyc();

        // extraction from 0x80F17F82
        load_and_check(0, 0, 1,  32'hFFFF_FF82);
        load_and_check(4, 3, 2,  32'h0000_0080);
        load_and_check(1, 2, 3,  32'hFFFF_80F1);
        load_and_check(5, 0, 9,  32'h0000_7F82);
        load_and_check(2, 0, 10, 32'h80F1_7F82);

        // load-use hazard on rd 7
        Rs1_addr = 5'd7;
        issue_load(2, 0, 7);
        cyc();
        Load_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 chk("hazard_stall", 32'(Stall), 32'd1);
            cyc();
        end
        Mem_ready = 1'b1; Mem_rdata = 32'h1234_5678;
        #1 chk("hazard_ready_stall", 32'(Stall), 32'd0);
        cyc();
        Mem_ready = 1'b0;
        chk("hazard_data", Write_data, 32'h1234_5678);
        Rs1_addr = 5'd8;
        issue_load(2, 0, 7);
        cyc();
        Load_valid = 1'b0;
        #1 chk("nohazard_stall", 32'(Stall), 32'd0);
        cyc(); cyc();
        Mem_ready = 1'b1; Mem_rdata = 32'h0000_0042;
        cyc();
        Mem_ready = 1'b0; Rs1_addr = 5'd0;

        // collision: load rd4=0x11 with ALU rd4=0x22
        issue_load(2, 0, 4);
        cyc();
        Load_valid = 1'b0;
        Mem_ready = 1'b1; Mem_rdata = 32'h11;
        Alu_valid = 1'b1; Alu_rd = 5'd4; Alu_result = 32'h22;
        cyc();
        quiet();
        chk("coll_first", Write_data, 32'h11);
        #1 chk("coll_skid_stall", 32'(Stall), 32'd1);
        cyc();
        chk("coll_second", Write_data, 32'h22);
        chk("coll_second_we", 32'(Write_En), 32'd1);

        // ALU + load together, held load during WAIT, then re-presented
        Alu_valid = 1'b1; Alu_rd = 5'd13; Alu_result = 32'h55;
        issue_load(4, 1, 14);
        cyc();
        Alu_valid = 1'b0;
        chk("dual_alu", Write_data, 32'h55);
        issue_load(2, 0, 15);
        #1 chk("wait_load_stall", 32'(Stall), 32'd1);
        Mem_ready = 1'b1; Mem_rdata = 32'h0000_AB00;
        cyc();
        Mem_ready = 1'b0;
        chk("lbu_off1", Write_data, 32'h0000_00AB);
        cyc();
        Load_valid = 1'b0;
        Mem_ready = 1'b1; Mem_rdata = 32'hCAFE_F00D;
        cyc();
        Mem_ready = 1'b0;
        chk("held_load", Write_data, 32'hCAFE_F00D);

        // illegal loads
        issue_load(2, 1, 6);
        cyc();
        Load_valid = 1'b0;
        chk("misalign_err", 32'(Load_error), 32'd1);
        chk("misalign_we",  32'(Write_En),   32'd0);
        cyc();
        chk("err_pulse", 32'(Load_error), 32'd0);
        issue_load(3, 0, 6);
        cyc();
        issue_load(1, 1, 6);
        cyc();
        Load_valid = 1'b0;
        cyc();

        // timeout, with an ALU write slipped in while waiting
        issue_load(2, 0, 11);
        cyc();
        Load_valid = 1'b0;
        Alu_valid = 1'b1; Alu_rd = 5'd16; Alu_result = 32'h77;
        cyc();
        Alu_valid = 1'b0;
        chk("wait_alu", Write_data, 32'h77);
        chk("to_early1", 32'(Load_error), 32'd0);
        cyc();
        chk("to_early2", 32'(Load_error), 32'd0);
        cyc();
        chk("to_early3", 32'(Load_error), 32'd0);
        cyc();
        chk("to_fire", 32'(Load_error), 32'd1);
        chk("to_we",   32'(Write_En),   32'd0);
        Mem_ready = 1'b1; Mem_rdata = 32'h9999_9999;
        cyc();
        Mem_ready = 1'b0;
        chk("to_late_ready", 32'(Write_En), 32'd0);

        // reset mid-load
        issue_load(2, 0, 12);
        cyc();
        Load_valid = 1'b0;
        Reset_n = 1'b0;
        cyc();
        Reset_n = 1'b1;
        Mem_ready = 1'b1; Mem_rdata = 32'hABCD_0123;
        cyc();
        Mem_ready = 1'b0;
        chk("rstwait_we",   32'(Write_En),   32'd0);
        chk("rstwait_addr", 32'(Write_addr), 32'd0);
        chk("rstwait_data", Write_data,      32'd0);
        chk("rstwait_err",  32'(Load_error), 32'd0);
        chk("rstwait_stall", 32'(Stall),     32'd0);

        repeat (3) cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
